// File: rtl/sd_spi_responder_if.sv
// sd_spi_responder_if
// SPI bus between an SD host (master) and the SD-card responder (slave).
//   spi_sclk  host -> card  SPI clock, mode 0
//   spi_cs_n  host -> card  chip select, active low
//   spi_mosi  host -> card  command bits
//   spi_miso  card -> host  response bits
`timescale 1ns/1ps
interface sd_spi_responder_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_sclk, output spi_cs_n, output spi_mosi, input spi_miso);
  modport slave  (input spi_sclk, input spi_cs_n, input spi_mosi, output spi_miso);
endinterface

// File: rtl/sd_spi_responder.sv
// sd_spi_responder
// Minimal SD-card SPI-mode responder. Answers CMD0/8/55/ACMD41/58/17 and
// streams a synthetic 512-byte block for CMD17 once initialised.
// Ports:
//   clk         system clock (the only clock)
//   res         synchronous active-high reset
//   spi         SPI bus, slave modport (sclk/cs_n/mosi in, miso out)
//   card_ready  set once ACMD41 initialisation has completed
//   last_cmd    index of the last fully received command frame
// Optional build macro: SD_RESP_CRC_CHECK_EN enables CRC7 checking of
// command frames; without it the CRC field is ignored.
//
// state  | meaning
// HUNT   | waiting for the 0,1 frame start bits
// CMD_RX | collecting the remaining 46 frame bits
// NCR    | one 0xFF byte before the response
// RESP   | R1 plus any R3/R7 trailer
// NAC    | 0xFF fill before the read data token
// TOKEN  | 0xFE start-block token
// DATA   | 512 data bytes
// CRC    | two 0xFF CRC bytes
`timescale 1ns/1ps
module sd_spi_responder #(
  parameter int ACMD41_RETRIES = 2,
  parameter int NAC_BYTES      = 4
) (
  input  logic                      clk,
  input  logic                      res,
  sd_spi_responder_if.slave         spi,
  output logic                      card_ready,
  output logic [5:0]                last_cmd
);
  typedef enum logic [2:0] {HUNT, CMD_RX, NCR, RESP, NAC, TOKEN, DATA, CRC} state_t;
  typedef enum logic [1:0] {K_R1, K_R7, K_R3, K_RD} kind_t;

  localparam logic [15:0] RETRIES  = 16'(ACMD41_RETRIES);
  localparam logic [9:0]  NAC_LAST = 10'(NAC_BYTES - 1);

  logic        r_sclk_m, r_sclk_s, r_sclk_d;
  logic        r_cs_m, r_cs_s, r_mosi_m, r_mosi_s;
  logic        w_rise, w_fall, w_cs_n, w_mosi;
  state_t      r_state, w_state_next;
  logic [47:0] r_frame, w_frame_next;
  logic [5:0]  r_bitcnt;
  logic [2:0]  r_bitidx;
  logic [9:0]  r_bytecnt;
  logic        r_last;
  logic        r_miso_q;
  logic        r_card_ready, r_app_cmd;
  logic [15:0] r_acmd_cnt;
  logic [5:0]  r_last_cmd;
  kind_t       r_kind;
  logic [7:0]  r_r1;
  logic        w_frame_done, w_tx_state, w_byte_end, w_resp_last, w_crc_ok;
  logic [5:0]  w_idx;
  logic [7:0]  w_cur_byte, w_idle_r1;
  logic        w_unused;

  always_ff @(posedge clk) begin
    if (res) begin
      r_sclk_m <= 1'b0; r_sclk_s <= 1'b0; r_sclk_d <= 1'b0;
      r_cs_m   <= 1'b1; r_cs_s   <= 1'b1;
      r_mosi_m <= 1'b1; r_mosi_s <= 1'b1;
    end else begin
      r_sclk_m <= spi.spi_sclk; r_sclk_s <= r_sclk_m; r_sclk_d <= r_sclk_s;
      r_cs_m   <= spi.spi_cs_n; r_cs_s   <= r_cs_m;
      r_mosi_m <= spi.spi_mosi; r_mosi_s <= r_mosi_m;
    end
  end

  assign w_rise       = r_sclk_s & ~r_sclk_d;
  assign w_fall       = ~r_sclk_s & r_sclk_d;
  assign w_cs_n       = r_cs_s;
  assign w_mosi       = r_mosi_s;
  assign w_frame_next = {r_frame[46:0], w_mosi};
  assign w_idx        = w_frame_next[45:40];
  assign w_frame_done = (r_state == CMD_RX) && w_rise && !w_cs_n && (r_bitcnt == 6'd47);
  assign w_tx_state   = (r_state != HUNT) && (r_state != CMD_RX);
  assign w_byte_end   = w_fall && !r_last && (r_bitidx == 3'd7);
  assign w_resp_last  = (r_kind == K_R1 || r_kind == K_RD) ? (r_bytecnt == 10'd0)
                                                           : (r_bytecnt == 10'd4);
  assign w_idle_r1    = {7'b0, ~r_card_ready};
  // Start bits, stop bit and (in the default build) the CRC field are not decoded.
  assign w_unused     = ^{r_frame[47], w_frame_next[47:46], w_frame_next[39:0]};

`ifdef SD_RESP_CRC_CHECK_EN
  function automatic logic [6:0] f_crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction
  assign w_crc_ok = (f_crc7(w_frame_next[47:8]) == w_frame_next[7:1]);
`else
  assign w_crc_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (res) r_state <= HUNT;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (w_cs_n) begin
      w_state_next = HUNT;
    end else begin
      case (r_state)
        HUNT:   if (w_rise && !r_frame[0] && w_mosi) w_state_next = CMD_RX;
        CMD_RX: if (w_frame_done) w_state_next = NCR;
        default: begin
          // r_last holds the final LSB for one more sclk before releasing miso.
          if (w_fall && r_last) begin
            w_state_next = HUNT;
          end else if (w_byte_end) begin
            case (r_state)
              NCR:   w_state_next = RESP;
              RESP:  if (w_resp_last && r_kind == K_RD) begin
                       if (NAC_BYTES == 0) w_state_next = TOKEN;
                       else                w_state_next = NAC;
                     end
              NAC:   if (r_bytecnt == NAC_LAST) w_state_next = TOKEN;
              TOKEN: w_state_next = DATA;
              DATA:  if (r_bytecnt == 10'd511) w_state_next = CRC;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // Byte currently being shifted out
  always_comb begin
    w_cur_byte = 8'hFF;
    case (r_state)
      RESP: begin
        if (r_bytecnt == 10'd0) begin
          w_cur_byte = r_r1;
        end else if (r_kind == K_R7) begin
          case (r_bytecnt[2:0])
            3'd1, 3'd2: w_cur_byte = 8'h00;
            3'd3:       w_cur_byte = {4'h0, r_frame[19:16]};
            default:    w_cur_byte = r_frame[15:8];
          endcase
        end else if (r_kind == K_R3) begin
          case (r_bytecnt[2:0])
            3'd1:    w_cur_byte = r_card_ready ? 8'hC0 : 8'h00;
            3'd2:    w_cur_byte = 8'hFF;
            3'd3:    w_cur_byte = 8'h80;
            default: w_cur_byte = 8'h00;
          endcase
        end
      end
      TOKEN:   w_cur_byte = 8'hFE;
      DATA:    w_cur_byte = r_frame[15:8] + r_bytecnt[7:0];
      default: w_cur_byte = 8'hFF;
    endcase
  end

  // Datapath and card state
  always_ff @(posedge clk) begin
    if (res) begin
      r_frame      <= '1;
      r_bitcnt     <= 6'd2;
      r_bitidx     <= 3'd0;
      r_bytecnt    <= 10'd0;
      r_last       <= 1'b0;
      r_miso_q     <= 1'b1;
      r_card_ready <= 1'b0;
      r_app_cmd    <= 1'b0;
      r_acmd_cnt   <= 16'd0;
      r_last_cmd   <= 6'd0;
      r_kind       <= K_R1;
      r_r1         <= 8'hFF;
    end else begin
      // A stale 0 left in bit 0 must not pair with the next 1 as a false start.
      if (w_cs_n || (r_state != HUNT && w_state_next == HUNT))
        r_frame[0] <= 1'b1;
      else if (w_rise && !w_tx_state)
        r_frame <= w_frame_next;

      if (r_state == HUNT)
        r_bitcnt <= 6'd2;
      else if (r_state == CMD_RX && w_rise)
        r_bitcnt <= r_bitcnt + 6'd1;

      if (w_cs_n || !w_tx_state)
        r_miso_q <= 1'b1;
      else if (w_fall && !r_last)
        r_miso_q <= w_cur_byte[3'd7 - r_bitidx];

      if (w_frame_done) begin
        r_bitidx   <= 3'd0;
        r_bytecnt  <= 10'd0;
        r_last     <= 1'b0;
        r_last_cmd <= w_idx;
        r_kind     <= K_R1;
        if (!w_crc_ok) begin
          r_r1 <= w_idle_r1 | 8'h08;
        end else begin
          r_app_cmd <= 1'b0;
          case (w_idx)
            6'd0: begin
              r_card_ready <= 1'b0;
              r_acmd_cnt   <= 16'd0;
              r_r1         <= 8'h01;
            end
            6'd8: begin
              r_kind <= K_R7;
              r_r1   <= w_idle_r1;
            end
            6'd55: begin
              r_app_cmd <= 1'b1;
              r_r1      <= w_idle_r1;
            end
            6'd41: begin
              if (!r_app_cmd) begin
                r_r1 <= w_idle_r1 | 8'h04;
              end else if (r_acmd_cnt < RETRIES) begin
                r_acmd_cnt <= r_acmd_cnt + 16'd1;
                r_r1       <= w_idle_r1;
              end else begin
                r_card_ready <= 1'b1;
                r_r1         <= 8'h00;
              end
            end
            6'd58: begin
              r_kind <= K_R3;
              r_r1   <= w_idle_r1;
            end
            6'd17: begin
              if (r_card_ready) begin
                r_kind <= K_RD;
                r_r1   <= 8'h00;
              end else begin
                r_r1 <= w_idle_r1 | 8'h04;
              end
            end
            default: r_r1 <= w_idle_r1 | 8'h04;
          endcase
        end
      end else if (w_tx_state && !w_cs_n && w_fall && !r_last) begin
        r_bitidx <= r_bitidx + 3'd1;
        if (r_bitidx == 3'd7) begin
          if (w_state_next != r_state)
            r_bytecnt <= 10'd0;
          else if ((r_state == RESP && w_resp_last) || (r_state == CRC && r_bytecnt == 10'd1))
            r_last <= 1'b1;
          else
            r_bytecnt <= r_bytecnt + 10'd1;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    spi.spi_miso = (w_cs_n || !w_tx_state) ? 1'b1 : r_miso_q;
    card_ready   = r_card_ready;
    last_cmd     = r_last_cmd;
  end
endmodule
